// File: rtl/prach_pkg.sv
// Shared constants and types for the PRACH deshape return path.
// Holds channel width, lane/size defaults and the output FSM state.
package prach_pkg;
  localparam int CHN_W   = 8;
  localparam int LANES_D = 3;
  localparam int SIZE_D  = 16;

  typedef enum logic [1:0] {
    IDLE,
    S0,
    S1
  } st_t;
endpackage

// File: rtl/prach_deshape1_ch.sv
// Per-lane de-interleaver: R-beat capture, sample-1 staging, output mux.
// All control strobes come from the shared top-level sequencer.
module prach_deshape_ch
  import prach_pkg::*;
#(
  parameter int SIZE = SIZE_D
) (
  input  logic            clk,
  input  logic            i_rst_n,
  input  logic            i_r_ld,
  input  logic            i_i_ld,
  input  logic            i_s1_sel,
  input  logic [SIZE-1:0] i_dp1,
  input  logic [SIZE-1:0] i_dp2,
  output logic [SIZE-1:0] o_dr,
  output logic [SIZE-1:0] o_di
);

  logic [SIZE-1:0] r_re0;
  logic [SIZE-1:0] r_re1;
  logic [SIZE-1:0] r_s1r;
  logic [SIZE-1:0] r_s1i;
  logic [SIZE-1:0] r_dr;
  logic [SIZE-1:0] r_di;

  // Sample 1 is staged at I-load so a following R-beat may reuse re0/re1.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_re0 <= '0;
      r_re1 <= '0;
      r_s1r <= '0;
      r_s1i <= '0;
      r_dr  <= '0;
      r_di  <= '0;
    end else begin
      if (i_r_ld) begin
        r_re0 <= i_dp1;
        r_re1 <= i_dp2;
      end
      if (i_i_ld) begin
        r_dr  <= r_re0;
        r_di  <= i_dp1;
        r_s1r <= r_re1;
        r_s1i <= i_dp2;
      end else if (i_s1_sel) begin
        r_dr <= r_s1r;
        r_di <= r_s1i;
      end
    end
  end

  assign o_dr = r_dr;
  assign o_di = r_di;

endmodule

// File: rtl/prach_deshape1.sv
// PRACH deshape: packed R/I pair beats back to one complex sample per lane.
// Owns the beat phase, output FSM, channel/sync tags and fault pulse.
module prach_deshape1
  import prach_pkg::*;
#(
  parameter int SIZE  = SIZE_D,
  parameter int LANES = LANES_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  var logic [SIZE-1:0] din_dp1 [LANES],
  input  var logic [SIZE-1:0] din_dp2 [LANES],
  input  logic             din_dv,
  input  logic [CHN_W-1:0] din_chn,
  input  logic             sync_in,
  output var logic [SIZE-1:0] dout_dr [LANES],
  output var logic [SIZE-1:0] dout_di [LANES],
  output logic             dout_dv,
  output logic [CHN_W-1:0] dout_chn,
  output logic             sync_out,
  output logic             err
);

  st_t              r_st;
  st_t              w_nxt;
  logic             r_ph;
  logic [CHN_W-1:0] r_chn;
  logic             r_sync;
  logic [CHN_W-1:0] r_chn_o;
  logic             r_sync_o;
  logic             r_err;
  logic             w_r_ld;
  logic             w_i_ld;
  logic             w_s1_sel;
  logic             w_fault;

  // A sync beat always restarts the pair, even mid-pair.
  assign w_r_ld  = din_dv & (sync_in | ~r_ph);
  assign w_i_ld  = din_dv & ~sync_in & r_ph;
  assign w_fault = (din_dv & sync_in & r_ph)
                 | (w_i_ld & (din_chn != r_chn));

  always_comb begin
    w_nxt    = IDLE;
    w_s1_sel = 1'b0;
    unique case (r_st)
      IDLE: w_nxt = w_i_ld ? S0 : IDLE;
      S0: begin
        w_s1_sel = ~w_i_ld;
        w_nxt    = w_i_ld ? S0 : S1;
      end
      S1:      w_nxt = w_i_ld ? S0 : IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st     <= IDLE;
      r_ph     <= 1'b0;
      r_chn    <= '0;
      r_sync   <= 1'b0;
      r_chn_o  <= '0;
      r_sync_o <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_st  <= w_nxt;
      r_err <= w_fault;
      if (w_r_ld) begin
        r_ph   <= 1'b1;
        r_chn  <= din_chn;
        r_sync <= sync_in;
      end else if (w_i_ld) begin
        r_ph <= 1'b0;
      end
      if (w_i_ld) begin
        r_chn_o  <= r_chn;
        r_sync_o <= r_sync;
      end else begin
        r_sync_o <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    prach_deshape_ch #(.SIZE(SIZE)) u_ch (
      .clk      (clk),
      .i_rst_n  (rst_n),
      .i_r_ld   (w_r_ld),
      .i_i_ld   (w_i_ld),
      .i_s1_sel (w_s1_sel),
      .i_dp1    (din_dp1[g]),
      .i_dp2    (din_dp2[g]),
      .o_dr     (dout_dr[g]),
      .o_di     (dout_di[g])
    );
  end

  assign dout_dv  = (r_st != IDLE);
  assign dout_chn = r_chn_o;
  assign sync_out = r_sync_o;
  assign err      = r_err;

endmodule

// File: tb/tb_prach_deshape1.sv
// Self-checking bench for prach_deshape1: table-driven pairs plus
// hand sequences for sync, fault and reset corners, via a scoreboard.
module tb_prach_deshape1;
  import prach_pkg::*;

  typedef logic [2:0][15:0] lv_t;

  typedef struct packed {
    lv_t        dr;
    lv_t        di;
    logic [7:0] chn;
    logic       sync;
  } smp_t;

  typedef struct {
    lv_t        r1;
    lv_t        r2;
    lv_t        i1;
    lv_t        i2;
    logic [7:0] chn;
    lv_t        e0r;
    lv_t        e0i;
    lv_t        e1r;
    lv_t        e1i;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] dp1 [3];
  logic [15:0] dp2 [3];
  logic        din_dv = 1'b0;
  logic [7:0]  din_chn = '0;
  logic        sync_in = 1'b0;
  logic [15:0] dr [3];
  logic [15:0] di [3];
  logic        dout_dv;
  logic [7:0]  dout_chn;
  logic        sync_out;
  logic        err;

  int   checks = 0;
  int   errors = 0;
  smp_t q[$];
  logic pend = 1'b0;
  logic exp_err = 1'b0;
  logic mon_en = 1'b0;
  logic [15:0] held0 = '0;
  int   run = 0;
  int   last_run = 0;
  int   err_seen = 0;
  vec_t vec [8];

  prach_deshape1 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_dp1  (dp1),
    .din_dp2  (dp2),
    .din_dv   (din_dv),
    .din_chn  (din_chn),
    .sync_in  (sync_in),
    .dout_dr  (dr),
    .dout_di  (di),
    .dout_dv  (dout_dv),
    .dout_chn (dout_chn),
    .sync_out (sync_out),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) exp_err <= pend;

  task automatic chk(input string n, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      smp_t g;
      smp_t e;
      for (int l = 0; l < 3; l++) begin
        g.dr[l] = dr[l];
        g.di[l] = di[l];
      end
      g.chn  = dout_chn;
      g.sync = sync_out;
      if (dout_dv) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_sample got=%h", g);
        end else begin
          e = q.pop_front();
          if (g !== e) begin
            errors++;
            $display("FAIL sample got=%h want=%h", g, e);
          end
        end
        held0 = dr[0];
        run++;
      end else begin
        checks++;
        if (dr[0] !== held0) begin
          errors++;
          $display("FAIL hold got=%h want=%h", dr[0], held0);
        end
        if (run != 0) last_run = run;
        run = 0;
      end
      checks++;
      if (err !== exp_err) begin
        errors++;
        $display("FAIL err got=%b want=%b", err, exp_err);
      end
      if (err === 1'b1) err_seen++;
    end
  end

  task automatic beat(input logic dv, input logic sy,
                      input logic [7:0] ch, input lv_t a,
                      input lv_t b, input logic e_err);
    din_dv  = dv;
    sync_in = sy;
    din_chn = ch;
    for (int l = 0; l < 3; l++) begin
      dp1[l] = a[l];
      dp2[l] = b[l];
    end
    pend = e_err;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic sy);
    for (int k = 0; k < n; k++) beat(1'b0, sy, 8'hEE, '1, '1, 1'b0);
  endtask

  task automatic expect_s(input lv_t r, input lv_t i,
                          input logic [7:0] ch, input logic sy);
    smp_t s;
    s.dr   = r;
    s.di   = i;
    s.chn  = ch;
    s.sync = sy;
    q.push_back(s);
  endtask

  task automatic do_reset(input int pending);
    rst_n   = 1'b0;
    din_dv  = 1'b0;
    sync_in = 1'b0;
    pend    = 1'b0;
    @(posedge clk);
    #2;
    if (mon_en) chk("rst_pending", 64'(q.size()), 64'(pending));
    q.delete();
    held0 = '0;
    for (int l = 0; l < 3; l++) begin
      chk("rst_dr", 64'(dr[l]), 64'h0);
      chk("rst_di", 64'(di[l]), 64'h0);
    end
    chk("rst_ctl", {60'h0, dout_dv, sync_out, err, 1'b0}, 64'h0);
    chk("rst_chn", 64'(dout_chn), 64'h0);
    mon_en = 1'b1;
    rst_n  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string n, input int run_want);
    idle(4, 1'b0);
    chk({n, "_q"}, 64'(q.size()), 64'h0);
    if (run_want > 0) chk({n, "_run"}, 64'(last_run), 64'(run_want));
  endtask

  lv_t ra, rb, ia, ib;
  int  e0;

  initial begin
    for (int l = 0; l < 3; l++) begin
      dp1[l] = '0;
      dp2[l] = '0;
    end
    for (int p = 0; p < 8; p++) begin
      for (int l = 0; l < 3; l++) begin
        vec[p].r1[l]  = 16'(l * 'h4000 + p * 'h10 + 'h001);
        vec[p].r2[l]  = 16'(l * 'h4000 + p * 'h10 + 'h002);
        vec[p].i1[l]  = 16'(l * 'h4000 + p * 'h10 + 'h101);
        vec[p].i2[l]  = 16'(l * 'h4000 + p * 'h10 + 'h102);
        vec[p].e0r[l] = 16'(l * 'h4000 + p * 'h10 + 'h001);
        vec[p].e0i[l] = 16'(l * 'h4000 + p * 'h10 + 'h101);
        vec[p].e1r[l] = 16'(l * 'h4000 + p * 'h10 + 'h002);
        vec[p].e1i[l] = 16'(l * 'h4000 + p * 'h10 + 'h102);
      end
      vec[p].chn = 8'(p + 8'h20);
    end

    idle(2, 1'b0);
    do_reset(0);

    // Basic pair with dense R then I.
    ra = {16'hA001, 16'h5001, 16'h0001};
    rb = {16'hA002, 16'h5002, 16'h0002};
    ia = {16'hA011, 16'h5011, 16'h0011};
    ib = {16'hA012, 16'h5012, 16'h0012};
    expect_s(ra, ia, 8'h01, 1'b0);
    expect_s(rb, ib, 8'h01, 1'b0);
    beat(1'b1, 1'b0, 8'h01, ra, rb, 1'b0);
    beat(1'b1, 1'b0, 8'h01, ia, ib, 1'b0);
    drain("basic", 2);
    chk("basic_dr0", 64'(held0), 64'h0002);

    // Eight back-to-back pairs.
    for (int p = 0; p < 8; p++) begin
      expect_s(vec[p].e0r, vec[p].e0i, vec[p].chn, 1'b0);
      expect_s(vec[p].e1r, vec[p].e1i, vec[p].chn, 1'b0);
      beat(1'b1, 1'b0, vec[p].chn, vec[p].r1, vec[p].r2, 1'b0);
      beat(1'b1, 1'b0, vec[p].chn, vec[p].i1, vec[p].i2, 1'b0);
    end
    drain("dense", 16);

    // Sync on R-beat; stray sync without dv inside the gap is ignored.
    ra = {16'h1111, 16'h2222, 16'h3333};
    rb = {16'h4444, 16'h5555, 16'h6666};
    ia = {16'h7777, 16'h8888, 16'h9999};
    ib = {16'hAAAA, 16'hBBBB, 16'hCCCC};
    expect_s(ra, ia, 8'h05, 1'b1);
    expect_s(rb, ib, 8'h05, 1'b0);
    beat(1'b1, 1'b1, 8'h05, ra, rb, 1'b0);
    idle(2, 1'b1);
    beat(1'b1, 1'b0, 8'h05, ia, ib, 1'b0);
    drain("sync", 2);

    // Sync mid-pair drops the half pair and flags it.
    e0 = err_seen;
    beat(1'b1, 1'b0, 8'h01, '1, '1, 1'b0);
    expect_s(ra, ia, 8'h02, 1'b1);
    expect_s(rb, ib, 8'h02, 1'b0);
    beat(1'b1, 1'b1, 8'h02, ra, rb, 1'b1);
    beat(1'b1, 1'b0, 8'h02, ia, ib, 1'b0);
    drain("resync", 2);
    chk("resync_errs", 64'(err_seen - e0), 64'h1);

    // Channel mismatch still emits the pair under the R-beat channel.
    e0 = err_seen;
    expect_s(ib, rb, 8'h03, 1'b0);
    expect_s(ia, ra, 8'h03, 1'b0);
    beat(1'b1, 1'b0, 8'h03, ib, ia, 1'b0);
    beat(1'b1, 1'b0, 8'h04, rb, ra, 1'b1);
    drain("chnerr", 2);
    chk("chnerr_errs", 64'(err_seen - e0), 64'h1);

    // Reset right after sample 0 suppresses sample 1.
    expect_s(ra, ia, 8'h07, 1'b0);
    expect_s(rb, ib, 8'h07, 1'b0);
    beat(1'b1, 1'b0, 8'h07, ra, rb, 1'b0);
    beat(1'b1, 1'b0, 8'h07, ia, ib, 1'b0);
    do_reset(1);

    // Recovery pair with a gap between R and I.
    expect_s(vec[3].e0r, vec[3].e0i, 8'h09, 1'b0);
    expect_s(vec[3].e1r, vec[3].e1i, 8'h09, 1'b0);
    beat(1'b1, 1'b0, 8'h09, vec[3].r1, vec[3].r2, 1'b0);
    idle(3, 1'b0);
    beat(1'b1, 1'b0, 8'h09, vec[3].i1, vec[3].i2, 1'b0);
    drain("post_rst", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
